// File: rtl/app_if_pkg.sv
// Shared MIG-7 app interface constants: command encodings and system bus widths,
// plus the executor action type used by the responder.
package app_if_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam int unsigned SYS_ADDR_WIDTH = 27;
    localparam int unsigned SYS_DATA_WIDTH = 128;
    localparam int unsigned SYS_MASK_WIDTH = SYS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        EXEC_IDLE,
        EXEC_READ,
        EXEC_WRITE,
        EXEC_DROP
    } exec_op_e;

endpackage

// File: rtl/app_resp_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; used for the app command
// queue and the write data queue. DEPTH must be a power of two, at least 2.
module app_resp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/app_mem_responder.sv
// MIG-7 app interface responder backed by an on-chip word array.
// Define APP_RESP_RANDOM_STALL_EN to add LFSR-driven backpressure on app_rdy/app_wdf_rdy.
module app_mem_responder
    import app_if_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = SYS_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = SYS_DATA_WIDTH,
    parameter int unsigned MEM_LOG2     = 10,
    parameter int unsigned CALIB_CYCLES = 64,
    parameter int unsigned RD_LATENCY   = 4,
    parameter int unsigned CMD_DEPTH    = 4,
    parameter int unsigned WDF_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    ui_rst,
    input  logic [ADDR_WIDTH-1:0]   app_addr,
    input  logic [2:0]              app_cmd,
    input  logic                    app_en,
    output logic                    app_rdy,
    input  logic                    app_hi_pri,
    input  logic [DATA_WIDTH-1:0]   app_wdf_data,
    input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    input  logic                    app_wdf_wren,
    input  logic                    app_wdf_end,
    output logic                    app_wdf_rdy,
    output logic [DATA_WIDTH-1:0]   app_rd_data,
    output logic                    app_rd_data_valid,
    output logic                    app_rd_data_end,
    output logic                    init_calib_complete
);

    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CMD_W      = MEM_LOG2 + 3;
    localparam int unsigned WDF_W      = DATA_WIDTH + MASK_WIDTH;
    localparam int unsigned CCW        = $clog2(CMD_DEPTH) + 1;
    localparam int unsigned WCW        = $clog2(WDF_DEPTH) + 1;
    localparam int unsigned CALW       = $clog2(CALIB_CYCLES + 1);

    localparam logic [CCW-1:0]  CMD_FULL  = CCW'(CMD_DEPTH);
    localparam logic [WCW-1:0]  WDF_FULL  = WCW'(WDF_DEPTH);
    localparam logic [CALW-1:0] CAL_LAST  = CALW'(CALIB_CYCLES - 1);

    logic            calibrated;
    logic [CALW-1:0] cal_cnt;

    logic             cmd_push, cmd_pop;
    logic [CMD_W-1:0] cmd_din, cmd_dout;
    logic [CCW-1:0]   cmd_count;
    logic             wdf_push, wdf_pop;
    logic [WDF_W-1:0] wdf_din, wdf_dout;
    logic [WCW-1:0]   wdf_count;

    logic [MEM_LOG2-1:0]   head_idx;
    logic [2:0]            head_cmd;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_WIDTH-1:0] wmask;
    exec_op_e              exec_op;

    logic [DATA_WIDTH-1:0] mem [2**MEM_LOG2];
    logic [DATA_WIDTH-1:0] pipe_data [RD_LATENCY];
    logic [RD_LATENCY-1:0] pipe_valid;

    logic cmd_space, wdf_space;
    logic unused_inputs;

    always_ff @(posedge clk or posedge ui_rst) begin
        if (ui_rst) begin
            cal_cnt    <= '0;
            calibrated <= 1'b0;
        end else if (!calibrated) begin
            if (cal_cnt == CAL_LAST) calibrated <= 1'b1;
            else                     cal_cnt    <= cal_cnt + 1'b1;
        end
    end

    assign init_calib_complete = calibrated;

    // Readiness uses registered occupancy only, so a same-cycle pop never frees a slot.
    assign cmd_space = cmd_count < CMD_FULL;
    assign wdf_space = wdf_count < WDF_FULL;

`ifdef APP_RESP_RANDOM_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge ui_rst) begin
        if (ui_rst) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign app_rdy     = calibrated && cmd_space && !lfsr[0];
    assign app_wdf_rdy = calibrated && wdf_space && !lfsr[1];
`else
    assign app_rdy     = calibrated && cmd_space;
    assign app_wdf_rdy = calibrated && wdf_space;
`endif

    assign cmd_push = app_en && app_rdy;
    assign cmd_din  = {app_addr[MEM_LOG2+2:3], app_cmd};
    assign wdf_push = app_wdf_wren && app_wdf_rdy;
    assign wdf_din  = {app_wdf_data, app_wdf_mask};

    app_resp_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH), .CW(CCW)) u_cmd_fifo (
        .clk   (clk),
        .rst   (ui_rst),
        .push  (cmd_push),
        .din   (cmd_din),
        .pop   (cmd_pop),
        .dout  (cmd_dout),
        .count (cmd_count)
    );

    app_resp_fifo #(.WIDTH(WDF_W), .DEPTH(WDF_DEPTH), .CW(WCW)) u_wdf_fifo (
        .clk   (clk),
        .rst   (ui_rst),
        .push  (wdf_push),
        .din   (wdf_din),
        .pop   (wdf_pop),
        .dout  (wdf_dout),
        .count (wdf_count)
    );

    assign head_idx = cmd_dout[CMD_W-1:3];
    assign head_cmd = cmd_dout[2:0];
    assign wdata    = wdf_dout[WDF_W-1:MASK_WIDTH];
    assign wmask    = wdf_dout[MASK_WIDTH-1:0];

    // A write at the head without paired data blocks everything behind it.
    always_comb begin
        exec_op = EXEC_IDLE;
        if (cmd_count != '0) begin
            if (head_cmd == CMD_READ) begin
                exec_op = EXEC_READ;
            end else if (head_cmd == CMD_WRITE) begin
                if (wdf_count != '0) exec_op = EXEC_WRITE;
            end else begin
                exec_op = EXEC_DROP;
            end
        end
    end

    assign cmd_pop = exec_op != EXEC_IDLE;
    assign wdf_pop = exec_op == EXEC_WRITE;

    always_ff @(posedge clk) begin
        if (exec_op == EXEC_WRITE) begin
            for (int unsigned b = 0; b < MASK_WIDTH; b++) begin
                if (!wmask[b]) mem[head_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        pipe_data[0] <= mem[head_idx];
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    always_ff @(posedge clk or posedge ui_rst) begin
        if (ui_rst) begin
            pipe_valid        <= '0;
            app_rd_data_valid <= 1'b0;
            app_rd_data       <= '0;
        end else begin
            pipe_valid        <= {pipe_valid[RD_LATENCY-2:0], exec_op == EXEC_READ};
            app_rd_data_valid <= pipe_valid[RD_LATENCY-1];
            if (pipe_valid[RD_LATENCY-1]) app_rd_data <= pipe_data[RD_LATENCY-1];
        end
    end

    assign app_rd_data_end = app_rd_data_valid;

    assign unused_inputs = ^{app_hi_pri, app_wdf_end, app_addr};

endmodule

// File: tb/tb_app_mem_responder.sv
// Directed plus randomized bench for app_mem_responder, checked against a
// command-ordered memory model kept in queues.
module tb_app_mem_responder;
    import app_if_pkg::*;

    localparam int CAL = 64;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         ui_rst = 1'b1;
    logic [26:0]  app_addr = '0;
    logic [2:0]   app_cmd = '0;
    logic         app_en = 1'b0;
    logic         app_rdy;
    logic         app_hi_pri = 1'b0;
    logic [127:0] app_wdf_data = '0;
    logic [15:0]  app_wdf_mask = '0;
    logic         app_wdf_wren = 1'b0;
    logic         app_wdf_end = 1'b0;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;
    logic         init_calib_complete;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    typedef struct {bit is_read; bit is_write; int idx; int due;} mcmd_t;
    typedef struct {logic [127:0] data; logic [15:0] mask;} mdat_t;
    typedef struct {logic [127:0] data; int due;} exp_t;

    mcmd_t        mcmd[$];
    mdat_t        mdat[$];
    exp_t         exp_q[$];
    logic [127:0] model_mem [int];

    app_mem_responder dut (
        .clk                 (clk),
        .ui_rst              (ui_rst),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_hi_pri          (app_hi_pri),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .app_rd_data_end     (app_rd_data_end),
        .init_calib_complete (init_calib_complete)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int word_of(input logic [26:0] a);
        return (int'(a) / 8) % 1024;
    endfunction

    // Retire model commands in order; a write waits for its data just as the initiator paired it.
    function automatic void resolve();
        mcmd_t        h;
        mdat_t        d;
        logic [127:0] w;
        while (mcmd.size() > 0) begin
            h = mcmd[0];
            if (h.is_write) begin
                if (mdat.size() == 0) break;
                d = mdat.pop_front();
                w = model_mem.exists(h.idx) ? model_mem[h.idx] : '0;
                for (int b = 0; b < 16; b++)
                    if (!d.mask[b]) w[b*8 +: 8] = d.data[b*8 +: 8];
                model_mem[h.idx] = w;
            end else if (h.is_read) begin
                exp_q.push_back('{model_mem.exists(h.idx) ? model_mem[h.idx] : 'x, h.due});
            end
            void'(mcmd.pop_front());
        end
    endfunction

    task automatic send_cmd(input logic [2:0] c, input logic [26:0] a, input bit timed);
        int n = 0;
        app_en = 1'b1; app_cmd = c; app_addr = a;
        while (!app_rdy && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("cmd_accept_timeout", app_rdy, 1);
        @(posedge clk); #1;
        app_en = 1'b0;
        mcmd.push_back('{c == CMD_READ, c == CMD_WRITE, word_of(a), timed ? cyc + LAT + 1 : -1});
        resolve();
    endtask

    task automatic send_data(input logic [127:0] d, input logic [15:0] m);
        int n = 0;
        app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = d; app_wdf_mask = m;
        while (!app_wdf_rdy && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("wdf_accept_timeout", app_wdf_rdy, 1);
        @(posedge clk); #1;
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        mdat.push_back('{d, m});
        resolve();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin idle(1); n++; end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        idle(8);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_app_rdy"}, app_rdy, 0);
        check({tag, "_wdf_rdy"}, app_wdf_rdy, 0);
        check({tag, "_rd_valid"}, app_rd_data_valid, 0);
        check({tag, "_rd_end"}, app_rd_data_end, 0);
        check({tag, "_rd_data"}, app_rd_data, 0);
        check({tag, "_calib"}, init_calib_complete, 0);
    endtask

    task automatic calib_phase(input string tag);
        logic e;
        for (int n = 1; n <= CAL + 6; n++) begin
            @(posedge clk); #1;
            e = (n >= CAL);
            check({tag, "_calib"}, init_calib_complete, e);
            check({tag, "_app_rdy"}, app_rdy, e);
            check({tag, "_wdf_rdy"}, app_wdf_rdy, e);
            check({tag, "_rd_valid"}, app_rd_data_valid, 0);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [26:0] mk_addr(input int idx);
        return {14'($urandom), 10'(idx), 3'($urandom)};
    endfunction

    // Read-return scoreboard; any valid with nothing outstanding is an extra beat.
    always @(negedge clk) begin
        exp_t e;
        if (!ui_rst && app_rd_data_valid) begin
            check("rd_end", app_rd_data_end, 1);
            if (exp_q.size() == 0) begin
                check("extra_valid", app_rd_data_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", app_rd_data, e.data);
                if (e.due >= 0) check("rd_latency", cyc, e.due);
            end
        end
    end

    initial begin
        int r;
        logic [127:0] d;

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        ui_rst = 1'b0;
        calib_phase("calib");

        send_data(128'h0123456789ABCDEF0123456789ABCDEF, 16'h0000);
        send_cmd(CMD_WRITE, 27'h80, 0);
        idle(3);
        send_cmd(CMD_READ, 27'h80, 1);
        drain();

        send_data('1, 16'h0000);
        send_cmd(CMD_WRITE, 27'h40, 0);
        send_data('0, 16'h00FF);
        send_cmd(CMD_WRITE, 27'h40, 0);
        send_cmd(CMD_READ, 27'h40, 0);
        drain();

        send_cmd(CMD_WRITE, 27'h200, 0);
        send_cmd(CMD_READ, 27'h200, 0);
        idle(3);
        send_data(rand128(), 16'h0000);
        drain();

        send_cmd(CMD_WRITE, 27'h100, 0);
        send_cmd(CMD_READ, 27'h80, 0);
        send_cmd(CMD_READ, 27'h40, 0);
        send_cmd(CMD_READ, 27'h200, 0);
        check("cmd_full", app_rdy, 0);
        idle(2);
        check("cmd_full_held", app_rdy, 0);
        send_data(rand128(), 16'h0000);
        check("cmd_full_pop_pending", app_rdy, 0);
        idle(1);
        check("cmd_ready_after_pop", app_rdy, 1);
        send_cmd(CMD_READ, 27'h100, 0);
        send_cmd(CMD_READ, 27'h80, 0);
        send_cmd(CMD_READ, 27'h200, 0);
        drain();

        for (int i = 0; i < 4; i++) send_data(rand128(), 16'($urandom));
        check("wdf_full", app_wdf_rdy, 0);
        send_cmd(CMD_WRITE, 27'h300, 0);
        check("wdf_full_pop_pending", app_wdf_rdy, 0);
        idle(1);
        check("wdf_ready_after_pop", app_wdf_rdy, 1);
        send_cmd(CMD_WRITE, 27'h308, 0);
        send_cmd(CMD_WRITE, 27'h310, 0);
        send_cmd(CMD_WRITE, 27'h318, 0);
        send_cmd(CMD_READ, 27'h300, 0);
        send_cmd(CMD_READ, 27'h318, 0);
        drain();

        for (int i = 0; i < 8; i++) begin
            send_data(rand128(), 16'h0000);
            send_cmd(CMD_WRITE, mk_addr(600 + i), 0);
        end
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                d = rand128();
                if ($urandom_range(0, 1) == 1) begin
                    send_data(d, 16'($urandom));
                    send_cmd(CMD_WRITE, mk_addr(600 + $urandom_range(0, 7)), 0);
                end else begin
                    send_cmd(CMD_WRITE, mk_addr(600 + $urandom_range(0, 7)), 0);
                    idle($urandom_range(0, 3));
                    send_data(d, 16'($urandom));
                end
            end else if (r <= 7) begin
                send_cmd(CMD_READ, mk_addr(600 + $urandom_range(0, 7)), 0);
            end else if (r == 8) begin
                send_cmd(3'($urandom_range(2, 7)), mk_addr(600), 0);
            end else begin
                idle($urandom_range(1, 4));
            end
        end
        drain();

        send_cmd(CMD_READ, 27'h80, 0);
        send_cmd(CMD_READ, 27'h40, 0);
        send_cmd(CMD_READ, 27'h200, 0);
        @(negedge clk);
        ui_rst = 1'b1;
        exp_q.delete(); mcmd.delete(); mdat.delete();
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        ui_rst = 1'b0;
        calib_phase("recal");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
